// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared types and constants for the unified-memory arbiter.
// Rev     : 1.0
// ============================================================================
package mem_arb_pkg;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int KERNEL_BIT = 31;
   localparam int TAG_W      = KERNEL_BIT - 2;

   // Clears the kernel flag and the byte offset in one step.
   localparam logic [ADDR_W-1:0] WORD_MASK = ~((ADDR_W'(1) << KERNEL_BIT) | ADDR_W'(3));

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_I = 2'd1,
      ARB_BUSY_D = 2'd2,
      ARB_RESP   = 2'd3
   } arb_state_t;

   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] addr);
      return addr & WORD_MASK;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_ibuf.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_ibuf
// Brief   : One-entry fetch buffer (tag, data, valid) with fill and store snoop.
// Rev     : 1.0
// ============================================================================
module mem_arb_ibuf
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [TAG_W-1:0]  lookup_tag,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data,
   input  logic              fill_en,
   input  logic [TAG_W-1:0]  fill_tag,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              inval_en,
   input  logic [TAG_W-1:0]  inval_tag
);

   logic              r_valid;
   logic [TAG_W-1:0]  r_tag;
   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
      end else if (fill_en) begin
         r_valid <= 1'b1;
         r_tag   <= fill_tag;
         r_data  <= fill_data;
      end else if (inval_en && (inval_tag == r_tag)) begin
         r_valid <= 1'b0;
      end
   end

   assign hit      = r_valid && (r_tag == lookup_tag);
   assign hit_data = r_data;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Single-port memory arbiter for IF/MEM with anti-starvation streak.
//           Optional fetch buffer enabled by defining MEMARB_IBUF_EN.
// Rev     : 1.0
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              d_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int                  STREAK_W     = $clog2(MAX_STREAK + 1);
   localparam logic [STREAK_W-1:0] c_STREAK_MAX = STREAK_W'(MAX_STREAK);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic                r_grant_d;
   logic [STREAK_W-1:0] r_streak;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_d_rdata;
   logic                w_take_d;
   logic                w_take_i;
   logic                w_ibuf_hit;
   logic [DATA_W-1:0]   w_ibuf_data;

`ifdef MEMARB_IBUF_EN
   mem_arb_ibuf u_ibuf (
      .clk        (clk),
      .reset      (reset),
      .lookup_tag (if_addr[KERNEL_BIT-1:2]),
      .hit        (w_ibuf_hit),
      .hit_data   (w_ibuf_data),
      .fill_en    ((r_state == ARB_BUSY_I) && mem_ack),
      .fill_tag   (r_mem_addr[KERNEL_BIT-1:2]),
      .fill_data  (mem_rdata),
      .inval_en   ((r_state == ARB_IDLE) && w_take_d && d_we),
      .inval_tag  (d_addr[KERNEL_BIT-1:2])
   );
`else
   assign w_ibuf_hit  = 1'b0;
   assign w_ibuf_data = '0;
`endif

   // Data wins unless a waiting fetch has already been passed over MAX_STREAK times.
   assign w_take_d = d_req && (!if_req || (r_streak < c_STREAK_MAX));
   assign w_take_i = if_req && !w_take_d;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_take_d)
               w_state_nxt = ARB_BUSY_D;
            else if (w_take_i)
               w_state_nxt = w_ibuf_hit ? ARB_RESP : ARB_BUSY_I;
         end
         ARB_BUSY_I, ARB_BUSY_D: begin
            if (mem_ack)
               w_state_nxt = ARB_RESP;
         end
         ARB_RESP: w_state_nxt = ARB_IDLE;
         default:  w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset)
         r_state <= ARB_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_grant_d   <= 1'b0;
         r_streak    <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (!if_req)
                  r_streak <= '0;
               if (w_take_d) begin
                  r_grant_d   <= 1'b1;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= d_we;
                  r_mem_addr  <= word_addr(d_addr);
                  r_mem_wdata <= d_wdata;
                  // With a fetch waiting, a data grant implies the streak is below MAX.
                  if (if_req)
                     r_streak <= r_streak + 1'b1;
               end else if (w_take_i) begin
                  r_grant_d <= 1'b0;
                  r_streak  <= '0;
                  if (w_ibuf_hit) begin
                     r_if_rdata <= w_ibuf_data;
                  end else begin
                     r_mem_req  <= 1'b1;
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= word_addr(if_addr);
                  end
               end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  if (r_grant_d)
                     r_d_rdata <= mem_rdata;
                  else
                     r_if_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign if_ready  = (r_state == ARB_RESP) && !r_grant_d;
   assign d_ready   = (r_state == ARB_RESP) && r_grant_d;
   assign if_stall  = if_req && !if_ready;
   assign d_stall   = d_req && !d_ready;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench for mem_arbiter: vector table, corner sequences,
//           and randomized traffic against a transaction-level memory model.
// Rev     : 1.0
// ============================================================================
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int MAX_STREAK = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ready, if_stall;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_ready, d_stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter #(.MAX_STREAK(MAX_STREAK)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] init_word(input int i);
      return (i == 0) ? 32'h3C01_1234 : 32'hA500_0000 + 32'(i) * 32'h0101_0101;
   endfunction

   function automatic logic [31:0] exp_maddr(input logic [31:0] a);
      return {1'b0, a[30:2], 2'b00};
   endfunction

   // Memory as seen by the DUT (written from mem_* outputs) and the requesters' view.
   logic [31:0] phys_mem [16];
   bit   [15:0] phys_written = '0;
   logic [31:0] ref_mem  [16];

   int   ack_delay = 0;
   logic extra_ack = 1'b0;
   int   wait_cnt = 0;
   int   req_rises = 0;
   logic p_req = 1'b0, p_we = 1'b0, p_rst = 1'b0;
   logic [31:0] p_addr = '0, p_wdata = '0;

   // Memory responder plus continuous stall/stability checks, all at the falling edge.
   always @(negedge clk) begin
      check("if_stall_eq", {31'b0, if_stall}, {31'b0, if_req & ~if_ready});
      check("d_stall_eq", {31'b0, d_stall}, {31'b0, d_req & ~d_ready});
      if (p_rst && mem_req && p_req && !mem_ack)
         check("mem_hold", {mem_we, mem_addr[30:0]} ^ mem_wdata, {p_we, p_addr[30:0]} ^ p_wdata);
      if (mem_req && !p_req) req_rises++;
      p_req = mem_req; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata; p_rst = reset;
      if (mem_req && reset) begin
         if (wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = phys_written[mem_addr[5:2]] ? phys_mem[mem_addr[5:2]] : init_word(int'(mem_addr[5:2]));
            if (mem_we) begin
               phys_mem[mem_addr[5:2]]     = mem_wdata;
               phys_written[mem_addr[5:2]] = 1'b1;
            end
            wait_cnt = 0;
         end else begin
            mem_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_ack  = extra_ack;
         wait_cnt = 0;
      end
   end

   // Run both requesters to completion, checking returned data against ref_mem.
   task automatic serve(output int first_d, output logic [31:0] g_addr, output logic g_we);
      int  n = 0;
      bit  got = 0;
      first_d = -1; g_addr = '0; g_we = 1'b0;
      while ((if_req || d_req) && n < 60) begin
         tick(); n++;
         if (mem_req && !got) begin got = 1; g_addr = mem_addr; g_we = mem_we; end
         if (if_ready) begin
            if (first_d < 0) first_d = 0;
            check("serve_if_rdata", if_rdata, ref_mem[if_addr[5:2]]);
            if_req = 1'b0;
         end
         if (d_ready) begin
            if (first_d < 0) first_d = 1;
            if (d_we) ref_mem[d_addr[5:2]] = d_wdata;
            else check("serve_d_rdata", d_rdata, ref_mem[d_addr[5:2]]);
            d_req = 1'b0;
         end
      end
      check("serve_done", {31'b0, if_req | d_req}, 32'd0);
   endtask

   typedef struct {
      logic ireq; logic [31:0] iaddr;
      logic dreq; logic dwe; logic [31:0] daddr; logic [31:0] dwdata;
      int delay;
      logic exp_d_first; logic [31:0] exp_addr; logic exp_we;
   } vec_t;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[7];
      int   first_d, n, dgrants, pulses, pcyc, run;
      logic [31:0] g_addr;
      logic g_we, g_if, g_d, seen;
      logic [31:0] r_addr, r_wdata;
      logic r_we;

      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      vecs[0] = '{1, 32'h8000_0008, 0, 0, 32'h0, 32'h0,         0, 0, 32'h0000_0008, 0};
      vecs[1] = '{0, 32'h0,         1, 0, 32'h10, 32'h0,        1, 1, 32'h0000_0010, 0};
      vecs[2] = '{0, 32'h0,         1, 1, 32'h07, 32'hDEADBEEF, 2, 1, 32'h0000_0004, 1};
      vecs[3] = '{1, 32'h8000_0024, 1, 0, 32'h30, 32'h0,        0, 1, 32'h0000_0030, 0};
      vecs[4] = '{1, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h0,         1, 0, 32'h7FFF_FFFC, 0};
      vecs[5] = '{0, 32'h0,         1, 1, 32'h8000_003B, 32'h1234_5678, 0, 1, 32'h0000_0038, 1};
      vecs[6] = '{1, 32'h0000_000C, 1, 0, 32'h04, 32'h0,        2, 1, 32'h0000_0004, 0};

      // Reset state
      tick(); tick(); tick();
      check("rst_mem_req", {31'b0, mem_req}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_ready", {30'b0, if_ready, d_ready}, 0);
      check("rst_state", 32'(dut.r_state), 32'(ARB_IDLE));
      check("rst_streak", 32'(dut.r_streak), 0);
      reset = 1'b1;
      tick();

      // Lone fetch, cycle exact
      ack_delay = 0; if_req = 1'b1; if_addr = 32'h8000_0000; #1;
      check("lone_stall_c0", {31'b0, if_stall}, 1);
      tick();
      check("lone_mem_req_c1", {31'b0, mem_req}, 1);
      check("lone_mem_addr", mem_addr, 32'h0);
      check("lone_mem_we", {31'b0, mem_we}, 0);
      check("lone_stall_c1", {31'b0, if_stall}, 1);
      tick();
      check("lone_ready_c2", {31'b0, if_ready}, 1);
      check("lone_rdata", if_rdata, 32'h3C01_1234);
      check("lone_stall_c2", {31'b0, if_stall}, 0);
      if_req = 1'b0;
      tick();
      check("lone_ready_pulse", {31'b0, if_ready}, 0);

      // Vector table
      for (int v = 0; v < 7; v++) begin
         ack_delay = vecs[v].delay;
         if_req = vecs[v].ireq; if_addr = vecs[v].iaddr;
         d_req = vecs[v].dreq; d_we = vecs[v].dwe; d_addr = vecs[v].daddr; d_wdata = vecs[v].dwdata;
         serve(first_d, g_addr, g_we);
         check($sformatf("vec%0d_first", v), 32'(first_d), {31'b0, vecs[v].exp_d_first});
         check($sformatf("vec%0d_addr", v), g_addr, vecs[v].exp_addr);
         check($sformatf("vec%0d_we", v), {31'b0, g_we}, {31'b0, vecs[v].exp_we});
         tick();
      end

      // Collision: data first, fetch issued after the post-response idle cycle
      ack_delay = 0;
      if_req = 1'b1; if_addr = 32'h8000_0014; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
      tick();
      check("coll_d_addr", mem_addr, 32'h10);
      check("coll_stall_a", {31'b0, if_stall}, 1);
      tick();
      check("coll_d_ready", {31'b0, d_ready}, 1);
      check("coll_d_rdata", d_rdata, ref_mem[4]);
      check("coll_stall_b", {31'b0, if_stall}, 1);
      d_req = 1'b0;
      tick();
      check("coll_idle_gap", {31'b0, mem_req}, 0);
      check("coll_stall_c", {31'b0, if_stall}, 1);
      tick();
      check("coll_i_req", {31'b0, mem_req}, 1);
      check("coll_i_addr", mem_addr, 32'h14);
      check("coll_stall_d", {31'b0, if_stall}, 1);
      tick();
      check("coll_i_ready", {31'b0, if_ready}, 1);
      check("coll_i_rdata", if_rdata, ref_mem[5]);
      if_req = 1'b0;
      tick();

      // Starvation: back-to-back loads with a fetch waiting
      if_req = 1'b1; if_addr = 32'h18; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      dgrants = 0; n = 0;
      while (!if_ready && n < 100) begin
         tick(); n++;
         if (d_ready) begin
            dgrants++;
            check("starve_d_rdata", d_rdata, ref_mem[d_addr[5:2]]);
            if (dgrants == MAX_STREAK) check("starve_streak_sat", 32'(dut.r_streak), MAX_STREAK);
            d_addr = d_addr + 32'd4;
         end
      end
      check("starve_fetch_ready", {31'b0, if_ready}, 1);
      check("starve_data_grants", 32'(dgrants), MAX_STREAK);
      check("starve_streak_zero", 32'(dut.r_streak), 0);
      check("starve_if_rdata", if_rdata, ref_mem[6]);
      if_req = 1'b0;
      serve(first_d, g_addr, g_we);
      tick();

      // Store with a 3-cycle-late ack
      ack_delay = 3; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h07; d_wdata = 32'hCAFE_F00D;
      tick();
      check("st_mem_req", {31'b0, mem_req}, 1);
      check("st_mem_addr", mem_addr, 32'h4);
      check("st_mem_we", {31'b0, mem_we}, 1);
      check("st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
      pulses = 0; pcyc = 0;
      for (int c = 2; c < 10; c++) begin
         tick();
         if (d_ready) begin pulses++; pcyc = c; d_req = 1'b0; end
      end
      check("st_pulses", 32'(pulses), 1);
      check("st_ready_cycle", 32'(pcyc), 5);
      check("st_phys_mem", phys_mem[1], 32'hCAFE_F00D);
      ref_mem[1] = 32'hCAFE_F00D;

      // Reset in the middle of a data access
      ack_delay = 20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
      tick(); tick();
      check("rm_busy", 32'(dut.r_state), 32'(ARB_BUSY_D));
      reset = 1'b0;
      tick();
      reset = 1'b1; d_req = 1'b0;
      check("rm_state", 32'(dut.r_state), 32'(ARB_IDLE));
      check("rm_mem_req", {31'b0, mem_req}, 0);
      check("rm_mem_we", {31'b0, mem_we}, 0);
      check("rm_mem_addr", mem_addr, 0);
      check("rm_mem_wdata", mem_wdata, 0);
      check("rm_rdata", if_rdata | d_rdata, 0);
      extra_ack = 1'b1;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (if_ready || d_ready || mem_req) pulses++;
      end
      extra_ack = 1'b0;
      check("rm_late_ack_ignored", 32'(pulses), 0);
      tick(); tick();

`ifdef MEMARB_IBUF_EN
      ack_delay = 0;
      n = req_rises; if_req = 1'b1; if_addr = 32'h8000_0020;
      serve(first_d, g_addr, g_we);
      check("ib_first_miss", 32'(req_rises - n), 1);
      tick();
      n = req_rises; if_req = 1'b1;
      serve(first_d, g_addr, g_we);
      check("ib_second_hit", 32'(req_rises - n), 0);
      tick();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h0BAD_CAFE;
      serve(first_d, g_addr, g_we);
      tick();
      n = req_rises; if_req = 1'b1;
      serve(first_d, g_addr, g_we);
      check("ib_after_store_miss", 32'(req_rises - n), 1);
      tick();
`else
      // Randomized traffic checked against data, address and arbitration rules
      run = 0; seen = 1'b0; g_if = 1'b0; g_d = 1'b0; r_addr = '0; r_we = 1'b0; r_wdata = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         if (mem_req && !seen) begin
            seen = 1'b1; g_if = if_req; g_d = d_req;
            r_addr = mem_addr; r_we = mem_we; r_wdata = mem_wdata;
         end
         if (if_ready) begin
            check("rnd_if_rdata", if_rdata, ref_mem[if_addr[5:2]]);
            check("rnd_if_addr", r_addr, exp_maddr(if_addr));
            check("rnd_if_we", {31'b0, r_we}, 0);
            check("rnd_arb_fetch", {31'b0, g_d && (run < MAX_STREAK)}, 0);
            run = 0; if_req = 1'b0; seen = 1'b0;
         end
         if (d_ready) begin
            check("rnd_d_addr", r_addr, exp_maddr(d_addr));
            check("rnd_d_we", {31'b0, r_we}, {31'b0, d_we});
            check("rnd_arb_data", {31'b0, g_if && (run >= MAX_STREAK)}, 0);
            run = g_if ? run + 1 : 0;
            if (d_we) begin
               check("rnd_d_wdata", r_wdata, d_wdata);
               ref_mem[d_addr[5:2]] = d_wdata;
            end else begin
               check("rnd_d_rdata", d_rdata, ref_mem[d_addr[5:2]]);
            end
            d_req = 1'b0; seen = 1'b0;
         end
         if (!mem_req) ack_delay = int'($urandom_range(0, 3));
         if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = $urandom();
         end
         if (!d_req && $urandom_range(0, 1) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom(); d_wdata = $urandom();
         end
      end
      serve(first_d, g_addr, g_we);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
